// File: rtl/lut_seq_eval.sv
// -----------------------------------------------------------------------------
// lut_seq_eval
//
// Purpose: stores the truth table of an N-input Boolean function. The table is
// loaded serially, one bit per cycle with index 0 first. It is read back in two
// ways: single-vector evaluation, with a latency of one cycle, or a full sweep
// that streams every table entry in index order.
//
// Optional feature: when the macro LUT_MINTERM_COUNT_EN is defined, every
// completed sweep counts the 1s it streamed and registers that count on
// minterm_count. When the macro is undefined, minterm_count is tied to zero and
// no counter logic exists.
//
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   load_start                  begin (or restart) a table load
//   load_valid, load_bit        serial table bit, index 0 first
//   load_ready, load_done       accepting bits / pulse on the last accepted bit
//   eval_valid, eval_in         evaluate F(eval_in); eval_in[N-1] is the MSB (A)
//   eval_ready                  high only while idle
//   f_valid, f_out              result one cycle after an accepted evaluation
//   scan_start                  begin a full-table sweep
//   scan_valid, scan_idx,
//   scan_bit, scan_done         sweep stream; scan_done marks the last entry
//   minterm_count               number of 1s seen in the last completed sweep
// -----------------------------------------------------------------------------
module lut_seq_eval #(
  parameter int NUM_INPUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_bit,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  eval_valid,
  input  logic [NUM_INPUTS-1:0] eval_in,
  output logic                  eval_ready,
  output logic                  f_valid,
  output logic                  f_out,
  input  logic                  scan_start,
  output logic                  scan_valid,
  output logic [NUM_INPUTS-1:0] scan_idx,
  output logic                  scan_bit,
  output logic                  scan_done,
  output logic [NUM_INPUTS:0]   minterm_count
);

  localparam int TBL = 1 << NUM_INPUTS;
  // The last table index is all ones, so the pointers never need to wrap.
  localparam logic [NUM_INPUTS-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TBL-1:0]        table_q, table_d;
  logic [NUM_INPUTS-1:0] ptr_q, ptr_d;
  logic [NUM_INPUTS-1:0] idx_q, idx_d;
  logic                  f_valid_q, f_valid_d;
  logic                  f_out_q, f_out_d;
  logic                  eval_ready_q, eval_ready_d;

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    f_valid_d  = 1'b0;
    f_out_d    = f_out_q;
    load_ready = 1'b0;
    load_done  = 1'b0;
    scan_valid = 1'b0;
    scan_done  = 1'b0;

    case (state_q)
      IDLE: begin
        // Fixed priority: a lower-priority request in the same cycle is dropped.
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (scan_start) begin
          state_d = SCAN;
          idx_d   = '0;
        end else if (eval_valid) begin
          f_valid_d = 1'b1;
          f_out_d   = table_q[eval_in];
        end
      end

      LOAD: begin
        load_ready = 1'b1;
        // A restart takes precedence over a bit presented in the same cycle.
        // Entries that were already written keep their values until they are
        // overwritten.
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid) begin
          table_d[ptr_q] = load_bit;
          if (ptr_q == LAST_IDX) begin
            load_done = 1'b1;
            state_d   = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      SCAN: begin
        scan_valid = 1'b1;
        if (idx_q == LAST_IDX) begin
          scan_done = 1'b1;
          state_d   = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // eval_ready is registered so that it reads 0 while reset is asserted,
    // even though the state register then already holds IDLE.
    eval_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      table_q      <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      f_valid_q    <= 1'b0;
      f_out_q      <= 1'b0;
      eval_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      f_valid_q    <= f_valid_d;
      f_out_q      <= f_out_d;
      eval_ready_q <= eval_ready_d;
    end
  end

  assign eval_ready = eval_ready_q;
  assign f_valid    = f_valid_q;
  assign f_out      = f_out_q;
  // Outside a sweep, the sweep data is forced to zero.
  assign scan_idx   = (state_q == SCAN) ? idx_q : '0;
  assign scan_bit   = (state_q == SCAN) ? table_q[idx_q] : 1'b0;

`ifdef LUT_MINTERM_COUNT_EN
  logic [NUM_INPUTS:0] ones_q, ones_d;
  logic [NUM_INPUTS:0] minterm_q, minterm_d;
  logic [NUM_INPUTS:0] ones_inc;

  // The running count includes the current entry, so the final entry is
  // counted in the same cycle that scan_done is high.
  assign ones_inc = ones_q + {{NUM_INPUTS{1'b0}}, scan_bit};

  always_comb begin
    ones_d    = ones_q;
    minterm_d = minterm_q;
    if (scan_valid) begin
      ones_d = ones_inc;
      if (scan_done) begin
        minterm_d = ones_inc;
        ones_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q    <= '0;
      minterm_q <= '0;
    end else begin
      ones_q    <= ones_d;
      minterm_q <= minterm_d;
    end
  end

  assign minterm_count = minterm_q;
`else
  assign minterm_count = '0;
`endif

endmodule

// File: tb/tb_lut_seq_eval.sv
module tb_lut_seq_eval;

  localparam int N   = 4;
  localparam int TBL = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_start, load_valid, load_bit;
  logic         load_ready, load_done;
  logic         eval_valid;
  logic [N-1:0] eval_in;
  logic         eval_ready, f_valid, f_out;
  logic         scan_start, scan_valid, scan_bit, scan_done;
  logic [N-1:0] scan_idx;
  logic [N:0]   minterm_count;

  int n_cmp = 0;
  int n_bad = 0;

  lut_seq_eval #(.NUM_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
    .load_ready(load_ready), .load_done(load_done),
    .eval_valid(eval_valid), .eval_in(eval_in), .eval_ready(eval_ready),
    .f_valid(f_valid), .f_out(f_out),
    .scan_start(scan_start), .scan_valid(scan_valid), .scan_idx(scan_idx),
    .scan_bit(scan_bit), .scan_done(scan_done), .minterm_count(minterm_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model, written from the block's observable rules: mode, the
  // table as a plain bit vector, the next table position, and the pending
  // evaluation result.
  int       m_mode = 0;       // 0 idle, 1 loading, 2 sweeping
  int       m_pos  = 0;       // load position or sweep position
  bit [15:0] m_tbl = '0;
  bit       m_fv = 0, m_fo = 0;
  int       m_mc = 0;
  bit       m_armed = 0;      // at least one clock edge since reset released

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_tbl = '0; m_fv = 0; m_fo = 0; m_mc = 0; m_armed = 0;
      chk("rst_load_ready", load_ready, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_eval_ready", eval_ready, 0);
      chk("rst_f_valid", f_valid, 0);
      chk("rst_f_out", f_out, 0);
      chk("rst_scan_valid", scan_valid, 0);
      chk("rst_scan_done", scan_done, 0);
      chk("rst_minterm", minterm_count, 0);
    end else begin
      chk("m_load_ready", load_ready, int'(m_mode == 1));
      chk("m_load_done", load_done,
          int'(m_mode == 1 && load_valid && !load_start && m_pos == TBL-1));
      chk("m_eval_ready", eval_ready, int'(m_mode == 0 && m_armed));
      chk("m_f_valid", f_valid, int'(m_fv));
      chk("m_f_out", f_out, int'(m_fo));
      chk("m_scan_valid", scan_valid, int'(m_mode == 2));
      chk("m_scan_idx", scan_idx, (m_mode == 2) ? m_pos : 0);
      chk("m_scan_bit", scan_bit, (m_mode == 2) ? int'(m_tbl[m_pos]) : 0);
      chk("m_scan_done", scan_done, int'(m_mode == 2 && m_pos == TBL-1));
      chk("m_minterm", minterm_count, m_mc);
      // Advance the model across the coming edge.
      m_fv = 0;
      if (m_mode == 0) begin
        if (load_start) begin m_mode = 1; m_pos = 0; end
        else if (scan_start) begin m_mode = 2; m_pos = 0; end
        else if (eval_valid) begin m_fv = 1; m_fo = m_tbl[eval_in]; end
      end else if (m_mode == 1) begin
        if (load_start) m_pos = 0;
        else if (load_valid) begin
          m_tbl[m_pos] = load_bit;
          if (m_pos == TBL-1) m_mode = 0; else m_pos++;
        end
      end else begin
        if (m_pos == TBL-1) begin
          m_mode = 0;
`ifdef LUT_MINTERM_COUNT_EN
          m_mc = $countones(m_tbl);
`endif
        end else m_pos++;
      end
      m_armed = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input bit [15:0] pat);
    load_start = 1; cyc(); load_start = 0;
    chk("load_ready_in_load", load_ready, 1);
    for (int i = 0; i < TBL; i++) begin
      load_valid = 1; load_bit = pat[i];
      #1;
      chk("load_done_position", load_done, int'(i == TBL-1));
      cyc();
    end
    load_valid = 0;
    chk("load_ready_after_load", load_ready, 0);
  endtask

  task automatic eval(input int v, input int exp);
    eval_valid = 1; eval_in = N'(v); cyc(); eval_valid = 0;
    chk("eval_f_valid", f_valid, 1);
    chk("eval_f_out", f_out, exp);
  endtask

  task automatic sweep(input bit [15:0] pat, input bit disturb, input int exp_mc);
    scan_start = 1; cyc(); scan_start = 0;
    for (int k = 0; k < TBL; k++) begin
      if (disturb && k == 3) load_start = 1;
      if (disturb && (k == 4 || k == 5)) begin eval_valid = 1; eval_in = 4'd4; end
      #1;
      chk("sweep_valid", scan_valid, 1);
      chk("sweep_idx", scan_idx, k);
      chk("sweep_bit", scan_bit, int'(pat[k]));
      chk("sweep_done", scan_done, int'(k == TBL-1));
      chk("sweep_eval_ready", eval_ready, 0);
      chk("sweep_f_valid", f_valid, 0);
      cyc();
      load_start = 0; eval_valid = 0;
    end
    chk("sweep_ended", scan_valid, 0);
`ifdef LUT_MINTERM_COUNT_EN
    chk("minterm_literal", minterm_count, exp_mc);
`else
    chk("minterm_literal", minterm_count, 0);
    if (exp_mc < 0) chk("minterm_arg", exp_mc, 0);
`endif
  endtask

  initial begin
    int  accepts;
    bit  seen;
    rst_n = 0; load_start = 0; load_valid = 0; load_bit = 0;
    eval_valid = 0; eval_in = '0; scan_start = 0;
    repeat (2) cyc();
    chk("reset_eval_ready", eval_ready, 0);
    chk("reset_load_ready", load_ready, 0);
    rst_n = 1;
    cyc();
    chk("eval_ready_after_release", eval_ready, 1);

    // Load 0xF0F0 and evaluate.
    load_table(16'hF0F0);
    eval(4, 1);
    eval(3, 0);
    eval(13, 1);

    // Plain sweep, then a sweep with ignored requests injected.
    sweep(16'hF0F0, 1'b0, 8);
    sweep(16'hF0F0, 1'b1, 8);
    eval(7, 1);

    // All three requests at once: load wins.
    load_start = 1; scan_start = 1; eval_valid = 1; eval_in = 4'd4;
    cyc();
    load_start = 0; scan_start = 0; eval_valid = 0;
    chk("prio_load_ready", load_ready, 1);
    chk("prio_f_valid", f_valid, 0);
    chk("prio_scan_valid", scan_valid, 0);

    // Seven bits, restart, then count the accepts needed for load_done.
    for (int i = 0; i < 7; i++) begin load_valid = 1; load_bit = 1; cyc(); end
    load_valid = 0; load_start = 1; cyc(); load_start = 0;
    accepts = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bit [15:0] p2;
      p2 = 16'h8001;
      load_valid = 1; load_bit = p2[i % 16];
      #1;
      accepts++;
      if (load_done) seen = 1;
      cyc();
    end
    load_valid = 0;
    chk("restart_accepts", seen ? accepts : 0, 16);
    eval(0, 1);
    eval(15, 1);
    eval(6, 0);
    sweep(16'h8001, 1'b0, 2);

    // Reset in the middle of a load.
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 5; i++) begin load_valid = 1; load_bit = 1; cyc(); end
    rst_n = 0; load_valid = 0;
    #1;
    chk("midrst_load_ready", load_ready, 0);
    chk("midrst_load_done", load_done, 0);
    chk("midrst_f_out", f_out, 0);
    chk("midrst_eval_ready", eval_ready, 0);
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    for (int v = 0; v < 5; v++) eval(v, 0);
    eval(15, 0);
    sweep(16'h0000, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
